// File: rtl/user_pkg.sv
// Shared types and constants for the user-domain register bank.
package user_pkg;

  // Per-register access behaviour.
  typedef enum logic [1:0] {
    REG_RW,
    REG_RO,
    REG_W1C
  } reg_mode_e;

  localparam int unsigned RegWindowBytes = 4096;
  localparam int unsigned RegDataWidth   = 32;
  localparam int unsigned RegBeWidth     = RegDataWidth / 8;

  // Stand-in for the SoC subordinate OBI ID width.
  localparam int unsigned SbrIdWidth = 1;

  // Data returned by reads that miss the window or are misaligned.
  localparam logic [RegDataWidth-1:0] ReadErrData = 32'hDEADBEEF;

  // Expand byte enables into a per-bit write mask.
  function automatic logic [RegDataWidth-1:0] be_to_mask(input logic [RegBeWidth-1:0] be);
    logic [RegDataWidth-1:0] mask;
    for (int unsigned b = 0; b < RegBeWidth; b++) begin
      mask[b*8 +: 8] = {8{be[b]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/user_reg_cell.sv
// One register of the user register bank.
// Ports: clk_i/rst_ni (sync active-low), wr_en_i (decoded, error-free write),
//        be_i/wdata_i (write payload), hw_status_i (RO source), hw_set_i (W1C set pulses),
//        q_o (current contents), q_next_c (value the register takes at the next edge).
module user_reg_cell
  import user_pkg::*;
#(
  parameter reg_mode_e   Mode      = REG_RW,
  parameter int unsigned DataWidth = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   wr_en_i,
  input  logic [DataWidth/8-1:0] be_i,
  input  logic [DataWidth-1:0]   wdata_i,
  input  logic [DataWidth-1:0]   hw_status_i,
  input  logic [DataWidth-1:0]   hw_set_i,
  output logic [DataWidth-1:0]   q_o,
  output logic [DataWidth-1:0]   q_next_c
);

  // Per-bit write mask from byte enables.
  logic [DataWidth-1:0] bit_mask;
  always_comb begin
    bit_mask = '0;
    for (int unsigned b = 0; b < DataWidth; b++) begin
      bit_mask[b] = be_i[b/8];
    end
  end

  if (Mode == REG_RO) begin : g_ro
    // Status mirror: no storage, software writes are rejected upstream.
    assign q_o      = hw_status_i;
    assign q_next_c = hw_status_i;
    logic unused_ro;
    assign unused_ro = ^{clk_i, rst_ni, wr_en_i, bit_mask, wdata_i, hw_set_i};
  end else begin : g_store
    logic [DataWidth-1:0] q;

    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        q <= '0;
      end else begin
        q <= q_next_c;
      end
    end

    assign q_o = q;

    if (Mode == REG_W1C) begin : g_w1c
      // Set is ORed in after the clear, so a simultaneous set wins.
      logic [DataWidth-1:0] clr;
      assign clr      = wr_en_i ? (wdata_i & bit_mask) : '0;
      assign q_next_c = (q & ~clr) | hw_set_i;
      logic unused_w1c;
      assign unused_w1c = ^hw_status_i;
    end else begin : g_rw
      assign q_next_c = wr_en_i ? ((q & ~bit_mask) | (wdata_i & bit_mask)) : q;
      logic unused_rw;
      assign unused_rw = ^{hw_status_i, hw_set_i};
    end
  end

endmodule

// File: rtl/user_reg_bank.sv
// OBI subordinate register bank for the user domain.
// Ports: clk_i/rst_ni (sync active-low); OBI request req_i/we_i/be_i/addr_i/wdata_i/aid_i,
//        grant gnt_o, response rvalid_o/rdata_o/rid_o/err_o (one cycle after grant);
//        hw_status_i/hw_set_i per-register hardware inputs, reg_q_o register contents,
//        irq_o registered OR of all W1C register bits.
module user_reg_bank
  import user_pkg::*;
#(
  parameter int unsigned       NumRegs   = 8,
  parameter int unsigned       DataWidth = 32,
  parameter int unsigned       AddrWidth = 32,
  parameter int unsigned       IdWidth   = SbrIdWidth,
  parameter logic [NumRegs-1:0] RoMask   = '0,
  parameter logic [NumRegs-1:0] W1cMask  = '0
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           req_i,
  input  logic                           we_i,
  input  logic [3:0]                     be_i,
  input  logic [AddrWidth-1:0]           addr_i,
  input  logic [DataWidth-1:0]           wdata_i,
  input  logic [IdWidth-1:0]             aid_i,
  output logic                           gnt_o,
  output logic                           rvalid_o,
  output logic [DataWidth-1:0]           rdata_o,
  output logic [IdWidth-1:0]             rid_o,
  output logic                           err_o,
  input  logic [NumRegs*DataWidth-1:0]   hw_status_i,
  input  logic [NumRegs*DataWidth-1:0]   hw_set_i,
  output logic [NumRegs*DataWidth-1:0]   reg_q_o,
  output logic                           irq_o
);

  localparam int unsigned OffWidth = $clog2(RegWindowBytes);
  localparam int unsigned IdxWidth = OffWidth - 2;

  // Elaboration-time parameter checks.
  if (DataWidth != 32) begin : g_bad_dw
    $fatal(1, "user_reg_bank: only DataWidth=32 is supported");
  end
  if (NumRegs < 1 || NumRegs > 1024) begin : g_bad_num
    $fatal(1, "user_reg_bank: NumRegs must be 1..1024");
  end
  if ((RoMask & W1cMask) != '0) begin : g_bad_mask
    $fatal(1, "user_reg_bank: a register cannot be both RO and W1C");
  end
  if (AddrWidth <= OffWidth) begin : g_bad_aw
    $fatal(1, "user_reg_bank: AddrWidth must exceed the window offset width");
  end

  // Every request is accepted immediately.
  assign gnt_o = req_i;

  // Decode.
  logic [OffWidth-1:0]  off;
  logic [IdxWidth-1:0]  idx;
  logic                 idx_valid;
  logic                 idx_ro;
  logic                 hit;
  logic                 err;
  logic                 wr_req;
  logic [DataWidth-1:0] rd_val;
  logic [DataWidth-1:0] cell_q    [NumRegs];
  logic [DataWidth-1:0] cell_next [NumRegs];
  logic                 irq_next;

  assign off = addr_i[OffWidth-1:0];
  assign idx = off[OffWidth-1:2];

  logic unused_addr;
  assign unused_addr = ^addr_i[AddrWidth-1:OffWidth];

  // Read mux and RO lookup; explicit compare avoids indexing past NumRegs.
  always_comb begin
    idx_valid = 1'b0;
    idx_ro    = 1'b0;
    rd_val    = '0;
    for (int unsigned i = 0; i < NumRegs; i++) begin
      if (idx == IdxWidth'(i)) begin
        idx_valid = 1'b1;
        idx_ro    = RoMask[i];
        rd_val    = cell_q[i];
      end
    end
  end

  assign hit    = (off[1:0] == 2'b00) && idx_valid;
  assign err    = !hit || (we_i && idx_ro);
  assign wr_req = req_i && we_i && !err;

  // Register cells.
  for (genvar i = 0; i < NumRegs; i++) begin : g_reg
    localparam reg_mode_e CellMode = RoMask[i]  ? REG_RO  :
                                     W1cMask[i] ? REG_W1C : REG_RW;
    logic wr_en;
    assign wr_en = wr_req && (idx == IdxWidth'(i));

    user_reg_cell #(
      .Mode      (CellMode),
      .DataWidth (DataWidth)
    ) u_cell (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .wr_en_i     (wr_en),
      .be_i        (be_i),
      .wdata_i     (wdata_i),
      .hw_status_i (hw_status_i[i*DataWidth +: DataWidth]),
      .hw_set_i    (hw_set_i[i*DataWidth +: DataWidth]),
      .q_o         (cell_q[i]),
      .q_next_c    (cell_next[i])
    );

    assign reg_q_o[i*DataWidth +: DataWidth] = cell_q[i];
  end

  // Interrupt follows the W1C next-values so it tracks the registers without extra lag.
  always_comb begin
    irq_next = 1'b0;
    for (int unsigned i = 0; i < NumRegs; i++) begin
      if (W1cMask[i]) begin
        irq_next = irq_next | (|cell_next[i]);
      end
    end
  end

  // Response pipeline register and interrupt register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rvalid_o <= 1'b0;
      err_o    <= 1'b0;
      rdata_o  <= '0;
      rid_o    <= '0;
      irq_o    <= 1'b0;
    end else begin
      rvalid_o <= req_i;
      if (req_i) begin
        rid_o   <= aid_i;
        err_o   <= err;
        rdata_o <= we_i ? '0 : (err ? DataWidth'(ReadErrData) : rd_val);
      end
      irq_o <= irq_next;
    end
  end

endmodule

// File: tb/tb_user_reg_bank.sv
// Self-checking bench for user_reg_bank: behavioural model plus directed and random traffic.
module tb_user_reg_bank;

  localparam int unsigned N  = 8;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned IW = 4;
  localparam logic [N-1:0] RO_M  = 8'h04;
  localparam logic [N-1:0] W1C_M = 8'h08;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            req, we;
  logic [3:0]      be;
  logic [AW-1:0]   addr;
  logic [DW-1:0]   wdata;
  logic [IW-1:0]   aid;
  logic            gnt, rvalid, err, irq;
  logic [DW-1:0]   rdata;
  logic [IW-1:0]   rid;
  logic [N*DW-1:0] hw_status, hw_set, reg_q;

  always #5 clk = ~clk;

  user_reg_bank #(
    .NumRegs   (N),
    .DataWidth (DW),
    .AddrWidth (AW),
    .IdWidth   (IW),
    .RoMask    (RO_M),
    .W1cMask   (W1C_M)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_i       (req),
    .we_i        (we),
    .be_i        (be),
    .addr_i      (addr),
    .wdata_i     (wdata),
    .aid_i       (aid),
    .gnt_o       (gnt),
    .rvalid_o    (rvalid),
    .rdata_o     (rdata),
    .rid_o       (rid),
    .err_o       (err),
    .hw_status_i (hw_status),
    .hw_set_i    (hw_set),
    .reg_q_o     (reg_q),
    .irq_o       (irq)
  );

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0]   m_regs [N];
  logic          m_live = 1'b0;
  logic          e_rvalid, e_err, e_irq;
  logic [31:0]   e_rdata;
  logic [IW-1:0] e_rid;

  always @(posedge clk) begin : p_model
    int          idx;
    logic        hit, rerr, wr;
    logic [31:0] mask, rv, clr;
    logic [31:0] nregs [N];
    logic        nirq;
    if (!rst_n) begin
      for (int i = 0; i < N; i++) nregs[i] = 32'h0;
      m_regs   <= nregs;
      e_rvalid <= 1'b0;
      e_err    <= 1'b0;
      e_rdata  <= 32'h0;
      e_rid    <= '0;
      e_irq    <= 1'b0;
      m_live   <= 1'b1;
    end else begin
      idx  = int'(addr[11:2]);
      hit  = (addr[1:0] == 2'b00) && (idx < N);
      rerr = hit ? (we && RO_M[idx]) : 1'b1;
      rv   = 32'h0;
      if (hit) rv = RO_M[idx] ? hw_status[idx*32 +: 32] : m_regs[idx];
      for (int b = 0; b < 4; b++) mask[b*8 +: 8] = {8{be[b]}};
      wr = req && we && !rerr;
      nirq = 1'b0;
      for (int i = 0; i < N; i++) begin
        nregs[i] = m_regs[i];
        if (W1C_M[i]) begin
          clr = (wr && idx == i) ? (wdata & mask) : 32'h0;
          nregs[i] = (m_regs[i] & ~clr) | hw_set[i*32 +: 32];
          nirq = nirq | (|nregs[i]);
        end else if (!RO_M[i] && wr && idx == i) begin
          nregs[i] = (m_regs[i] & ~mask) | (wdata & mask);
        end
      end
      m_regs   <= nregs;
      e_rvalid <= req;
      if (req) begin
        e_rid   <= aid;
        e_err   <= rerr;
        e_rdata <= we ? 32'h0 : (rerr ? 32'hDEADBEEF : rv);
      end
      e_irq <= nirq;
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    if (m_live) begin
      chk("rvalid", 32'(rvalid), 32'(e_rvalid));
      chk("gnt", 32'(gnt), 32'(req));
      if (e_rvalid) begin
        chk("rid", 32'(rid), 32'(e_rid));
        chk("err", 32'(err), 32'(e_err));
        chk("rdata", rdata, e_rdata);
      end
      chk("irq", 32'(irq), 32'(e_irq));
      for (int i = 0; i < N; i++) begin
        chk($sformatf("reg_q[%0d]", i), reg_q[i*32 +: 32],
            RO_M[i] ? hw_status[i*32 +: 32] : m_regs[i]);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One request cycle; returns at posedge+1 with the response on the outputs.
  task automatic access(input logic w, input logic [31:0] a, input logic [3:0] b,
                        input logic [31:0] d, output logic [IW-1:0] id);
    id    = IW'($urandom);
    req   = 1'b1;
    we    = w;
    addr  = a;
    be    = b;
    wdata = d;
    aid   = id;
    tick();
    req = 1'b0;
    we  = 1'b0;
  endtask

  logic [IW-1:0] id;

  initial begin
    rst_n     = 1'b0;
    req       = 1'b0;
    we        = 1'b0;
    be        = 4'h0;
    addr      = '0;
    wdata     = '0;
    aid       = '0;
    hw_set    = '0;
    hw_status = '0;
    hw_status[2*32 +: 32] = 32'hCAFE_0002;
    repeat (3) tick();
    chk("reset_rvalid", 32'(rvalid), 32'h0);
    chk("reset_irq", 32'(irq), 32'h0);
    chk("reset_reg0", reg_q[31:0], 32'h0);
    rst_n = 1'b1;
    tick();

    // Full write then read.
    access(1'b1, 32'h000, 4'hF, 32'h1234_5678, id);
    access(1'b0, 32'h000, 4'hF, 32'h0, id);
    chk("rd0_rvalid", 32'(rvalid), 32'h1);
    chk("rd0_data", rdata, 32'h1234_5678);
    chk("rd0_err", 32'(err), 32'h0);
    chk("rd0_rid", 32'(rid), 32'(id));

    // Partial byte write.
    access(1'b1, 32'h000, 4'b0101, 32'hAABB_CCDD, id);
    access(1'b0, 32'h000, 4'hF, 32'h0, id);
    chk("be_merge", rdata, 32'h12BB_56DD);

    // Back-to-back write then read of the same register.
    access(1'b1, 32'h004, 4'hF, 32'h5555_AAAA, id);
    access(1'b0, 32'h004, 4'hF, 32'h0, id);
    chk("b2b_read", rdata, 32'h5555_AAAA);

    // Zero byte-enable write changes nothing.
    access(1'b1, 32'h004, 4'h0, 32'hFFFF_FFFF, id);
    chk("be0_err", 32'(err), 32'h0);
    access(1'b0, 32'h004, 4'hF, 32'h0, id);
    chk("be0_read", rdata, 32'h5555_AAAA);

    // RO register.
    access(1'b0, 32'h008, 4'hF, 32'h0, id);
    chk("ro_read", rdata, 32'hCAFE_0002);
    chk("ro_read_err", 32'(err), 32'h0);
    access(1'b1, 32'h008, 4'hF, 32'h0, id);
    chk("ro_write_err", 32'(err), 32'h1);
    chk("ro_value", reg_q[2*32 +: 32], 32'hCAFE_0002);

    // W1C register.
    hw_set[3*32 +: 32] = 32'h11;
    tick();
    hw_set = '0;
    chk("w1c_irq_rise", 32'(irq), 32'h1);
    access(1'b0, 32'h00C, 4'hF, 32'h0, id);
    chk("w1c_read", rdata, 32'h11);
    access(1'b1, 32'h00C, 4'hF, 32'h01, id);
    access(1'b0, 32'h00C, 4'hF, 32'h0, id);
    chk("w1c_partial", rdata, 32'h10);
    chk("w1c_irq_hold", 32'(irq), 32'h1);
    access(1'b1, 32'h00C, 4'hF, 32'h10, id);
    chk("w1c_irq_fall", 32'(irq), 32'h0);

    // Simultaneous set and clear: set wins.
    hw_set[3*32 +: 32] = 32'h1;
    access(1'b1, 32'h00C, 4'hF, 32'h1, id);
    hw_set = '0;
    access(1'b0, 32'h00C, 4'hF, 32'h0, id);
    chk("set_wins", rdata, 32'h1);
    chk("set_wins_irq", 32'(irq), 32'h1);
    access(1'b1, 32'h00C, 4'hF, 32'h1, id);

    // Out-of-window and misaligned accesses.
    access(1'b0, 32'h020, 4'hF, 32'h0, id);
    chk("oow_err", 32'(err), 32'h1);
    chk("oow_data", rdata, 32'hDEAD_BEEF);
    access(1'b0, 32'h002, 4'hF, 32'h0, id);
    chk("misal_err", 32'(err), 32'h1);
    chk("misal_data", rdata, 32'hDEAD_BEEF);
    access(1'b1, 32'h020, 4'hF, 32'h0, id);
    chk("oow_wr_err", 32'(err), 32'h1);

    // Random traffic.
    for (int n = 0; n < 1500; n++) begin
      req   = ($urandom % 4) != 0;
      we    = $urandom % 2;
      addr  = 32'($urandom_range(0, 9) * 4);
      if ($urandom % 8 == 0) addr[1:0] = 2'($urandom);
      if ($urandom % 4 == 0) addr[31:12] = 20'($urandom);
      be    = 4'($urandom);
      wdata = $urandom;
      aid   = IW'($urandom);
      for (int i = 0; i < N; i++) begin
        hw_set[i*32 +: 32]    = ($urandom % 5 == 0) ? (32'h1 << ($urandom % 32)) : 32'h0;
        hw_status[i*32 +: 32] = $urandom;
      end
      tick();
    end
    req    = 1'b0;
    hw_set = '0;
    tick();

    // Reset asserted in the cycle a read is granted.
    access(1'b1, 32'h000, 4'hF, 32'hFFFF_FFFF, id);
    hw_set[3*32 +: 32] = 32'h4;
    tick();
    hw_set = '0;
    req   = 1'b1;
    we    = 1'b0;
    addr  = 32'h000;
    aid   = IW'($urandom);
    rst_n = 1'b0;
    tick();
    req = 1'b0;
    chk("rst_mid_rvalid", 32'(rvalid), 32'h0);
    chk("rst_mid_irq", 32'(irq), 32'h0);
    chk("rst_mid_reg0", reg_q[0*32 +: 32], 32'h0);
    chk("rst_mid_reg3", reg_q[3*32 +: 32], 32'h0);
    rst_n = 1'b1;
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
